bpsk_tx_scheduler: RTL and testbench

Frame-level controller for the BPSK modulator. Arbitrates byte-stream frames from N_REQ requesters (round-robin), optionally prepends a preamble, and feeds one byte per modulator symbol-group using the modulator's `data_finish` pulse. Holds the modulator in reset between frames and enforces an idle guard interval. Sits between packet sources and the BPSK modulator's `data_in` / `n_rst` / `data_finish` ports.

---
 rtl/bpsk_tx_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_bpsk_tx_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_scheduler.sv
// bpsk_tx_scheduler
// Frame-level controller in front of the BPSK modulator. Picks one of N_REQ
// byte-stream requesters round-robin and holds the modulator in reset while
// the first byte is loaded. It then hands the modulator one byte per
// data_finish pulse and afterwards keeps the modulator in reset for a guard
// interval.
//
// Optional feature: define BPSK_SCHED_PREAMBLE_EN to prepend PREAMBLE_LEN
// copies of PREAMBLE_BYTE to every frame. Without the macro no preamble
// logic is built and the first payload byte is taken in the grant cycle.
module bpsk_tx_scheduler #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    N_REQ         = 2,
    parameter int                    PREAMBLE_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_BYTE = 8'h55,
    parameter int                    GUARD_CYCLES  = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N_REQ-1:0]                           req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]                req_data,
    input  logic [N_REQ-1:0]                           req_last,
    output logic [N_REQ-1:0]                           req_ready,
    output logic                                       mod_n_rst,
    output logic [DATA_WIDTH-1:0]                      mod_data,
    input  logic                                       mod_finish,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant,
    output logic                                       busy,
    output logic                                       frame_done,
    output logic                                       underrun
);

    localparam int GW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GCW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GCW-1:0] GUARD_LOAD = GCW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Round-robin bookkeeping: until the first grant after reset the search
    // starts at index 0, afterwards it starts just past the last grant.
    logic           granted_once;
    int             rr_base;
    logic           pick_valid;
    logic [GW-1:0]  pick_idx;

    // Byte source currently addressed: the candidate in IDLE, the owner
    // of the frame otherwise.
    logic [GW-1:0]         src_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    // Frame progress.
    logic           last_seen;
    logic [GCW-1:0] guard_cnt;
    logic           pre_pending;

    // Decoded events for the current cycle.
    logic idle_take;
    logic fin_run;
    logic run_pre;
    logic run_take;
    logic run_done;
    logic run_under;

`ifdef BPSK_SCHED_PREAMBLE_EN
    localparam int PCW = $clog2(PREAMBLE_LEN + 1);
    logic [PCW-1:0] pre_cnt;

    // Preamble bytes still owed for this frame.
    assign pre_pending = (pre_cnt < PCW'(PREAMBLE_LEN));
`else
    assign pre_pending = 1'b0;
`endif

    // Find the first valid requester in rotating order from rr_base.
    // NOTE: every variable of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rr_base    = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        if (granted_once && (int'(grant) != N_REQ - 1)) begin
            rr_base = int'(grant) + 1;
        end
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pick_valid && req_valid[i] &&
                    ((i == rr_base + k) || (i == rr_base + k - N_REQ))) begin
                    pick_valid = 1'b1;
                    pick_idx   = GW'(i);
                end
            end
        end
    end

    assign src_idx = (state == IDLE) ? pick_idx : grant;

    // Multiplex the addressed requester's valid, last flag and byte.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (src_idx == GW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Decode what happens on the coming edge. A mod_finish only matters in
    // RUN; the priority is preamble, then end of frame, then next payload
    // byte, and an empty requester aborts the frame.
    always_comb begin
        idle_take = (state == IDLE) && pick_valid;
        fin_run   = (state == RUN) && mod_finish;
        run_pre   = fin_run && pre_pending;
        run_done  = fin_run && !pre_pending && last_seen;
        run_take  = fin_run && !pre_pending && !last_seen && sel_valid;
        run_under = fin_run && !pre_pending && !last_seen && !sel_valid;
    end

    // State register.
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (idle_take) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                if (run_done || run_under) begin
                    state_next = GUARD;
                end
            end
            GUARD: begin
                if (guard_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Combinational outputs: one-hot ready to the granted source only, and
    // the busy flag. Ready is held low while reset is asserted so a waiting
    // requester cannot see a handshake during reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifndef BPSK_SCHED_PREAMBLE_EN
            if (idle_take && (pick_idx == GW'(i))) begin
                req_ready[i] = 1'b1;
            end
`endif
            if (run_take && (grant == GW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
        if (rst) begin
            req_ready = '0;
        end
        busy = (state != IDLE);
    end

    // Frame datapath: modulator byte and reset, grant, counters, pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_n_rst    <= 1'b0;
            mod_data     <= '0;
            grant        <= '0;
            granted_once <= 1'b0;
            last_seen    <= 1'b0;
            guard_cnt    <= '0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
`ifdef BPSK_SCHED_PREAMBLE_EN
            pre_cnt      <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_take) begin
                        grant        <= pick_idx;
                        granted_once <= 1'b1;
`ifdef BPSK_SCHED_PREAMBLE_EN
                        mod_data     <= PREAMBLE_BYTE;
                        pre_cnt      <= PCW'(1);
                        last_seen    <= 1'b0;
`else
                        mod_data     <= sel_data;
                        last_seen    <= sel_last;
`endif
                    end
                end
                LOAD: begin
                    mod_n_rst <= 1'b1;
                end
                RUN: begin
                    if (run_pre) begin
                        mod_data <= PREAMBLE_BYTE;
`ifdef BPSK_SCHED_PREAMBLE_EN
                        pre_cnt  <= pre_cnt + PCW'(1);
`endif
                    end
                    if (run_take) begin
                        mod_data  <= sel_data;
                        last_seen <= sel_last;
                    end
                    if (run_done || run_under) begin
                        mod_n_rst  <= 1'b0;
                        guard_cnt  <= GUARD_LOAD;
                        frame_done <= run_done;
                        underrun   <= run_under;
                    end
                end
                GUARD: begin
                    if (guard_cnt != '0) begin
                        guard_cnt <= guard_cnt - GCW'(1);
                    end
                end
                default: begin
                    mod_n_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Self-checking bench for bpsk_tx_scheduler. Requesters are byte queues,
// the modulator's data_finish is generated by the bench, and a frame-level
// reference model predicts every output each cycle.
module tb_bpsk_tx_scheduler;

    localparam int DW    = 8;
    localparam int NR    = 2;
    localparam int PLEN  = 4;
    localparam int GUARD = 16;
    localparam logic [7:0] PB = 8'h55;
`ifdef BPSK_SCHED_PREAMBLE_EN
    localparam int PRE = PLEN;
`else
    localparam int PRE = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic            mod_n_rst;
    logic [DW-1:0]   mod_data;
    logic            mod_finish = 1'b0;
    logic [0:0]      grant;
    logic            busy;
    logic            frame_done;
    logic            underrun;

    bpsk_tx_scheduler #(
        .DATA_WIDTH(DW), .N_REQ(NR), .PREAMBLE_LEN(PLEN),
        .PREAMBLE_BYTE(PB), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .mod_n_rst(mod_n_rst), .mod_data(mod_data), .mod_finish(mod_finish),
        .grant(grant), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Requester sources: {last, byte} entries; hold[i] hides a non-empty queue.
    logic [8:0] src_q [NR][$];
    bit         hold [NR];
    int         hold_mode = 0;   // 0 none, 1 drop req0 after its first byte, 2 random
    int         fin_mode  = 0;   // 0 never, 1 every 4th cycle, 2 random, 3 always
    int         cyc = 0;

    // Frame-level reference model.
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_GUARD} mphase_t;
    mphase_t    ph;
    int         m_grant;
    bit         m_first;
    int         pre_left;
    bit         m_last_sent;
    int         guard_left;
    logic [7:0] e_data;
    bit         e_nrst, e_done, e_under;
    bit         load_evt, start_evt;

    // Observations of the DUT.
    logic [7:0] obs_seq[$];
    int         dut_grants[$];
    int         low_runs[$];
    int         low_cnt = 0;
    int         n_done = 0, n_under = 0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void reset_model();
        ph = M_IDLE; m_grant = 0; m_first = 0; pre_left = 0; m_last_sent = 0;
        guard_left = 0; e_data = 8'h00; e_nrst = 0; e_done = 0; e_under = 0;
        load_evt = 0; start_evt = 0;
    endfunction

    // Round-robin: first valid index after the last grant; index 0 first after reset.
    function automatic int rr_pick();
        int start;
        start = m_first ? (m_grant + 1) % NR : 0;
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    function automatic bit sources_idle();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic apply_inputs();
        cyc++;
        case (fin_mode)
            0: mod_finish = 1'b0;
            1: mod_finish = ((cyc % 4) == 0);
            2: mod_finish = ($urandom_range(0, 3) == 0);
            default: mod_finish = 1'b1;
        endcase
        for (int i = 0; i < NR; i++) begin
            if (hold_mode == 2) hold[i] = ($urandom_range(0, 24) == 0);
            if (hold_mode == 1 && i == 0 && src_q[0].size() == 2) hold[0] = 1'b1;
            req_valid[i] = (src_q[i].size() > 0) && !hold[i];
            req_last[i] = 1'b0;
            req_data[i*DW +: DW] = '0;
            if (src_q[i].size() > 0) begin
                req_last[i] = src_q[i][0][8];
                req_data[i*DW +: DW] = src_q[i][0][7:0];
            end
        end
    endtask

    function automatic void end_frame();
        e_nrst = 0;
        guard_left = GUARD - 1;
        ph = M_GUARD;
    endfunction

    // One clock: drive, compare everything, then advance the model across the edge.
    task automatic cycle();
        int pick;
        logic [NR-1:0] e_ready;
        logic [8:0] w;
        bit fin_run;
        apply_inputs();
        #1;
        if (load_evt) obs_seq.push_back(mod_data);
        if (start_evt) dut_grants.push_back(int'(grant));
        load_evt = 0; start_evt = 0;
        if (frame_done === 1'b1) n_done++;
        if (underrun === 1'b1) n_under++;
        if (mod_n_rst === 1'b1) begin
            if (low_cnt > 0) low_runs.push_back(low_cnt);
            low_cnt = 0;
        end else begin
            low_cnt++;
        end

        check("mod_n_rst", 32'(mod_n_rst), 32'(e_nrst));
        check("mod_data", 32'(mod_data), 32'(e_data));
        check("grant", 32'(grant), 32'(m_grant));
        check("busy", 32'(busy), 32'(ph != M_IDLE));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("underrun", 32'(underrun), 32'(e_under));

        e_ready = '0;
        pick = (ph == M_IDLE) ? rr_pick() : -1;
        if (pick >= 0 && PRE == 0) e_ready[pick] = 1'b1;
        fin_run = (ph == M_RUN) && mod_finish;
        if (fin_run && pre_left == 0 && !m_last_sent && req_valid[m_grant]) e_ready[m_grant] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(e_ready));

        e_done = 0; e_under = 0;
        case (ph)
            M_IDLE: if (pick >= 0) begin
                m_grant = pick; m_first = 1; load_evt = 1; start_evt = 1;
                if (PRE > 0) begin
                    e_data = PB; pre_left = PRE - 1; m_last_sent = 0;
                end else begin
                    w = src_q[pick].pop_front();
                    m_last_sent = w[8]; e_data = w[7:0]; pre_left = 0;
                end
                ph = M_LOAD;
            end
            M_LOAD: begin e_nrst = 1; ph = M_RUN; end
            M_RUN: if (fin_run) begin
                if (pre_left > 0) begin
                    e_data = PB; pre_left--; load_evt = 1;
                end else if (m_last_sent) begin
                    e_done = 1; end_frame();
                end else if (req_valid[m_grant]) begin
                    w = src_q[m_grant].pop_front();
                    m_last_sent = w[8]; e_data = w[7:0]; load_evt = 1;
                end else begin
                    e_under = 1; end_frame();
                end
            end
            default: begin
                if (guard_left == 0) ph = M_IDLE;
                else guard_left--;
            end
        endcase
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(ph == M_IDLE && sources_idle()) && n < max_cyc);
        check({name, "_bound"}, 32'(n < max_cyc), 32'd1);
    endtask

    // Assert reset (asynchronously, off the clock edge) and pin the reset values.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_n_rst", 32'(mod_n_rst), 32'd0);
        check("rst_data", 32'(mod_data), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_under", 32'(underrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        low_cnt = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_seq[$];
        int d0, u0, base_cnt;
        for (int i = 0; i < NR; i++) hold[i] = 1'b0;
        reset_model();
        @(negedge clk);
        do_reset();

        // mod_finish held high in IDLE: nothing loads, no ready.
        fin_mode = 3;
        repeat (6) cycle();
        check("idle_fin_data", 32'(mod_data), 32'h00);

        // 3-byte frame then a single-byte 0x81 frame on req0.
        fin_mode = 1;
        obs_seq.delete();
        exp_seq.delete();
        for (int p = 0; p < PRE; p++) exp_seq.push_back(PB);
        exp_seq.push_back(8'hA5); exp_seq.push_back(8'h3C); exp_seq.push_back(8'hFF);
        for (int p = 0; p < PRE; p++) exp_seq.push_back(PB);
        exp_seq.push_back(8'h81);
        src_q[0].push_back({1'b0, 8'hA5});
        src_q[0].push_back({1'b0, 8'h3C});
        src_q[0].push_back({1'b1, 8'hFF});
        src_q[0].push_back({1'b1, 8'h81});
        d0 = n_done;
        run_until_idle("two_frames", 600);
        check("seq_len", 32'(obs_seq.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < obs_seq.size(); i++)
            check("seq_byte", 32'(obs_seq[i]), 32'(exp_seq[i]));
        check("two_frames_done", 32'(n_done - d0), 32'd2);
        check("guard_low_len", 32'(low_runs[low_runs.size()-1]), 32'd18);
        check("last_data_81", 32'(mod_data), 32'h81);

        // Both requesters continuously valid after reset: grants 0,1,0,1.
        do_reset();
        dut_grants.delete();
        src_q[0].push_back({1'b0, 8'h10}); src_q[0].push_back({1'b1, 8'h11});
        src_q[0].push_back({1'b1, 8'h12});
        src_q[1].push_back({1'b1, 8'h20});
        src_q[1].push_back({1'b0, 8'h21}); src_q[1].push_back({1'b1, 8'h22});
        run_until_idle("alternate", 800);
        check("alt_count", 32'(dut_grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < dut_grants.size(); i++)
            check("alt_grant", 32'(dut_grants[i]), 32'(i % 2));

        // req0 drops valid after its first payload byte: underrun, no frame_done.
        d0 = n_done; u0 = n_under;
        hold_mode = 1;
        src_q[0].push_back({1'b0, 8'h11});
        src_q[0].push_back({1'b0, 8'h22});
        src_q[0].push_back({1'b1, 8'h33});
        run_until_idle("underrun", 400);
        check("underrun_pulses", 32'(n_under - u0), 32'd1);
        check("underrun_no_done", 32'(n_done - d0), 32'd0);
        hold_mode = 0; hold[0] = 1'b0;
        src_q[0].delete();

        // Reset mid-payload: frame lost silently; next grant starts from 0.
        d0 = n_done; u0 = n_under;
        for (int b = 0; b < 4; b++) src_q[1].push_back({(b == 3), 8'hD1 + 8'(b)});
        base_cnt = 0;
        while (!(ph == M_RUN && pre_left == 0 && src_q[1].size() <= 2) && base_cnt < 300) begin
            cycle();
            base_cnt++;
        end
        check("midrst_reach", 32'(base_cnt < 300), 32'd1);
        src_q[1].delete();
        do_reset();
        repeat (20) cycle();
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        check("midrst_no_under", 32'(n_under - u0), 32'd0);
        dut_grants.delete();
        src_q[0].push_back({1'b1, 8'hE1});
        src_q[1].push_back({1'b1, 8'hE2});
        run_until_idle("after_rst", 400);
        check("after_rst_first", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd0);

        // mod_finish held high through RUN, GUARD and IDLE.
        d0 = n_done;
        fin_mode = 3;
        src_q[0].push_back({1'b1, 8'hC7});
        run_until_idle("fin_high", 400);
        repeat (5) cycle();
        check("fin_high_data", 32'(mod_data), 32'hC7);
        check("fin_high_done", 32'(n_done - d0), 32'd1);

        // Randomized traffic: random frames, finish spacing and short stalls.
        fin_mode = 2;
        hold_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int s, len;
            s = $urandom_range(0, NR - 1);
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++)
                src_q[s].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
        end
        run_until_idle("random", 12000);
        hold_mode = 0;
        for (int i = 0; i < NR; i++) hold[i] = 1'b0;
        run_until_idle("drain", 4000);
        check("drain_empty", 32'(src_q[0].size() + src_q[1].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
